// File: rtl/mode_counter_pkg.sv
// Shared encodings for the mode counter: terminal-count modes and FSM states.
// Imported by the counter top and by any block that drives its mode field.
package mode_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;
   localparam logic [1:0] MODE_RELOAD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mode_counter_if.sv
// Control and status bundle between a register block (master) and the mode counter (slave).
interface mode_counter_if #(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
);

   logic                      clear;
   logic                      start;
   logic                      load;
   logic                      enable;
   logic                      up;
   logic [1:0]                mode;
   logic [WIDTH-1:0]          D;
   logic [WIDTH-1:0]          limit;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [WIDTH-1:0]          Q;
   logic                      tc;
   logic                      running;
   logic                      done;

   modport master (
      output clear, start, load, enable, up, mode, D, limit, prescale,
      input  Q, tc, running, done
   );

   modport slave (
      input  clear, start, load, enable, up, mode, D, limit, prescale,
      output Q, tc, running, done
   );

endinterface

// File: rtl/mode_counter_tick_prescaler.sv
// Divides enabled cycles down to one tick every prescale+1 of them; reusable by other timers.
module tick_prescaler #(
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] count;

   // A count already past prescale simply runs on and wraps through zero.
   assign tick = en && !clr && (count == prescale);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + PRESCALE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mode_counter.sv
// Programmable up/down counter with limit, four terminal-count modes, prescaler and run/done status.
module mode_counter
   import mode_counter_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   mode_counter_if.slave bus
);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             tc_q;
   logic             tc_d;
   logic             tick;
   logic             terminal;

   // Load restarts the division phase so the first tick after it is a full period away.
   tick_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.clear || bus.load),
      .en       ((state_q == ST_RUN) && bus.enable),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         tc_q    <= tc_d;
      end
   end

   // Terminal test uses >= going up so a count left above a lowered limit still terminates.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      tc_d     = 1'b0;
      terminal = bus.up ? (q_q >= bus.limit) : (q_q == '0);

      if (bus.clear) begin
         q_d     = '0;
         state_d = ST_IDLE;
      end else if (bus.load) begin
         q_d     = bus.D;
         state_d = ST_RUN;
      end else if (bus.start && (state_q != ST_RUN)) begin
         state_d = ST_RUN;
      end else if (tick) begin
         if (!terminal) begin
            q_d = bus.up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
         end else begin
            tc_d = 1'b1;
            case (bus.mode)
               MODE_WRAP:    q_d     = bus.up ? '0 : bus.limit;
               MODE_SAT:     q_d     = bus.up ? bus.limit : '0;
               MODE_ONESHOT: state_d = ST_DONE;
               default:      q_d     = bus.D;
            endcase
         end
      end
   end

   assign bus.Q       = q_q;
   assign bus.tc      = tc_q;
   assign bus.running = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: directed scenarios then random traffic, checked against a cycle model.
module tb_mode_counter;
   import mode_counter_pkg::*;

   localparam int WIDTH = 8;
   localparam int PW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mode_counter_if #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) bus ();

   mode_counter #(
      .WIDTH          (WIDTH),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass   = 0;

   // Reference model: plain integers for count and prescaler phase, two flags for run/done.
   int mq;
   int mphase;
   bit mrun;
   bit mdone;
   bit mtc;

   function automatic void modelReset();
      mq = 0; mphase = 0; mrun = 0; mdone = 0; mtc = 0;
   endfunction

   task automatic modelStep();
      int lim;
      bit term;
      lim = int'(bus.limit);
      mtc = 0;
      if (bus.clear) begin
         mq = 0; mphase = 0; mrun = 0; mdone = 0;
      end else if (bus.load) begin
         mq = int'(bus.D); mphase = 0; mrun = 1; mdone = 0;
      end else if (bus.start && !mrun) begin
         mrun = 1; mdone = 0;
      end else if (mrun && bus.enable) begin
         if (mphase == int'(bus.prescale)) begin
            mphase = 0;
            term = bus.up ? (mq >= lim) : (mq == 0);
            if (!term) begin
               mq = bus.up ? (mq + 1) % 256 : (mq + 255) % 256;
            end else begin
               mtc = 1;
               if (bus.mode == MODE_WRAP)         mq = bus.up ? 0 : lim;
               else if (bus.mode == MODE_SAT)     mq = bus.up ? lim : 0;
               else if (bus.mode == MODE_ONESHOT) begin mrun = 0; mdone = 1; end
               else                               mq = int'(bus.D);
            end
         end else begin
            mphase = (mphase + 1) % (1 << PW);
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      nChecks++;
      assert (bus.Q === WIDTH'(mq)) nPass++;
      else $error("[TB] FAIL %s Q: got %0d expected %0d", tag, bus.Q, mq);
      nChecks++;
      assert (bus.tc === mtc) nPass++;
      else $error("[TB] FAIL %s tc: got %0b expected %0b", tag, bus.tc, mtc);
      nChecks++;
      assert (bus.running === mrun) nPass++;
      else $error("[TB] FAIL %s running: got %0b expected %0b", tag, bus.running, mrun);
      nChecks++;
      assert (bus.done === mdone) nPass++;
      else $error("[TB] FAIL %s done: got %0b expected %0b", tag, bus.done, mdone);
   endtask

   task automatic applyStimulus(input bit c, input bit s, input bit l, input string tag);
      @(negedge clk);
      bus.clear = c;
      bus.start = s;
      bus.load  = l;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic runCycles(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      bus.clear = 0; bus.start = 0; bus.load = 0; bus.enable = 0; bus.up = 1;
      bus.mode = MODE_WRAP; bus.D = '0; bus.limit = 8'd5; bus.prescale = '0;
      modelReset();
      #12;
      checkOutput("reset");
      rst = 1'b0;

      $display("[TB] idle without start");
      bus.enable = 1;
      runCycles(20, "idle");

      $display("[TB] wrap up and down");
      applyStimulus(0, 1, 0, "wrap_start");
      runCycles(6, "wrap_up");
      bus.up = 0;
      runCycles(3, "wrap_down");

      $display("[TB] prescaler and enable gating");
      bus.up = 1; bus.limit = 8'd255; bus.prescale = 4'd2;
      applyStimulus(1, 0, 0, "ps_clear");
      applyStimulus(0, 1, 0, "ps_start");
      runCycles(8, "ps_run");
      bus.enable = 0;
      runCycles(4, "ps_frozen");
      bus.enable = 1;
      runCycles(6, "ps_resume");

      $display("[TB] saturate and oneshot");
      bus.prescale = 4'd0; bus.mode = MODE_SAT; bus.limit = 8'd3; bus.D = 8'd1;
      applyStimulus(0, 0, 1, "sat_load");
      runCycles(7, "sat_run");
      bus.mode = MODE_ONESHOT; bus.up = 0; bus.D = 8'd4;
      applyStimulus(0, 0, 1, "one_load");
      runCycles(7, "one_run");
      applyStimulus(0, 1, 0, "one_restart");
      runCycles(3, "one_again");

      $display("[TB] reload down");
      bus.mode = MODE_RELOAD; bus.D = 8'd2;
      applyStimulus(0, 0, 1, "rel_load");
      runCycles(6, "rel_run");
      bus.D = 8'd7;
      runCycles(4, "rel_newd");

      $display("[TB] priority and async reset");
      applyStimulus(1, 0, 1, "clear_vs_load");
      bus.mode = MODE_WRAP; bus.up = 1; bus.limit = 8'd3; bus.D = 8'd3;
      applyStimulus(0, 0, 1, "load_at_limit");
      bus.D = 8'd1;
      applyStimulus(0, 0, 1, "load_vs_tc");
      runCycles(2, "post_load");
      #1;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("async_reset");
      #1;
      rst = 1'b0;

      $display("[TB] random traffic");
      bus.prescale = 4'd0;
      for (int i = 0; i < 400; i++) begin
         bus.enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) bus.up = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 11) == 0) bus.limit = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 7) == 0) bus.D = 8'($urandom_range(0, 20));
         if ($urandom_range(0, 19) == 0) bus.prescale = 4'($urandom_range(0, 3));
         applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 24) == 0, "random");
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised successor to the basic load/up/down counter, intended for timers, baud and tick generators, and event counting.
- Adds a programmable limit, four terminal-count modes, a prescaler, start/clear control, a terminal-count pulse and run status.
- Sits between bus-written control registers and logic that consumes periodic ticks or timeouts.

Parameters:
WIDTH, 8, width of count value, load value and limit
PRESCALE_WIDTH, 4, width of the prescaler divide value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous clear: Q=0, prescaler=0, state IDLE
start  in  1  single-cycle pulse: enter RUN from IDLE/DONE; Q unchanged
load  in  1  synchronous load: Q=D, prescaler=0, state RUN
enable  in  1  count gate; low freezes Q and the prescaler
up  in  1  1 = count up, 0 = count down
mode  in  2  0 WRAP, 1 SATURATE, 2 ONESHOT, 3 RELOAD
D  in  WIDTH  load and reload value
limit  in  WIDTH  upper bound of the count range [0, limit]
prescale  in  PRESCALE_WIDTH  tick every prescale+1 enabled cycles
Q  out  WIDTH  count value
tc  out  1  terminal-count pulse, one clk wide
running  out  1  state == RUN
done  out  1  state == DONE (ONESHOT finished)

Behaviour:
- Reset (async) and clear (sync) drive: Q=0, tc=0, prescaler=0, state IDLE, running=0, done=0.
- States:
  - IDLE: no counting. start -> RUN; load -> RUN with Q=D.
  - RUN: counts on ticks.
  - DONE: no counting. start -> RUN; load -> RUN.
- Priority within a cycle: clear > load > start > tick.
- Prescaler:
  - Increments on cycles where state==RUN and enable=1.
  - tick=1 when the prescaler equals prescale; the prescaler then returns to 0.
  - prescale=0 gives a tick on every enabled RUN cycle.
  - The prescaler holds in IDLE/DONE and when enable=0.
  - prescale changes take effect on the next comparison. If the prescaler is already above prescale, it wraps naturally at 2^PRESCALE_WIDTH.
- Terminal condition, evaluated on Q before the update:
  - up: Q >= limit (covers Q above limit after a load or a limit change).
  - down: Q == 0.
- Non-terminal tick: Q <= Q+1 (up) or Q-1 (down). All arithmetic is WIDTH bits.
- Terminal tick, by mode:
  - WRAP: up Q<=0; down Q<=limit.
  - SATURATE: up Q<=limit; down Q<=0. Q is clamped and holds there.
  - ONESHOT: Q unchanged; state -> DONE.
  - RELOAD: Q<=D, in either direction.
- tc: registered. It is 1 in the cycle after every terminal tick and 0 otherwise.
  - In SATURATE, tc pulses on every tick while held at the bound.
  - In ONESHOT, tc pulses exactly once.
- Latency: Q, tc and state all update on the clk edge that samples the tick. running and done are decoded from the state register.
- mode, up and limit changes mid-run apply at the next tick.
- limit=0:
  - up counting is always terminal.
  - WRAP/SATURATE hold Q=0 with tc every tick.
- load during a tick cycle: the load wins and no tc is produced.
- clear or rst mid-run aborts immediately. No tc is produced.

Decomposition:
- Shared package mode_counter_pkg holds:
  - mode encodings MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2, MODE_RELOAD=2'd3.
  - state encodings ST_IDLE, ST_RUN, ST_DONE (2 bits).
- One sub-module: tick_prescaler.
  - Parameter PRESCALE_WIDTH.
  - Ports clk, rst, clr, en, prescale, tick.
  - Reusable by other timer blocks.

Test Plan:
- Reset then idle: after rst, Q=0, running=0, done=0. With enable=1 and no start for 20 cycles, Q stays 0 and tc=0.
- WRAP up: limit=5, prescale=0, start. Q goes 0,1,2,3,4,5,0,1…, with tc high in the cycle Q returns to 0. Down from 0 gives 5 with tc.
- Prescaler and enable: prescale=2, WRAP up, limit=255. Q advances once per 3 enabled cycles. Holding enable low for 4 cycles freezes both Q and the prescaler phase.
- SATURATE and ONESHOT:
  - SATURATE up, limit=3: Q holds at 3 and tc pulses every tick.
  - ONESHOT down, load D=4: Q goes 4,3,2,1,0, then done=1 and running=0 with a single tc. A later start resumes RUN.
- RELOAD down: D=2, load. Q goes 2,1,0,2,1,0 with tc after each 0. Changing D to 7 mid-run makes the next reload go to 7.
- Priority and async reset:
  - clear and load in the same cycle gives Q=0, IDLE.
  - load coinciding with a terminal tick gives Q=D and tc=0.
  - rst asserted mid-count zeroes all outputs without waiting for clk.
